// File: rtl/vpi_struct_bank_pkg.sv
// Shared types and helpers for the vpi_struct_bank storage bank.
//   state_e  : clear-sequencer states
//   idx_w()  : index width helper, max(1, $clog2(n))
//   even_par : even-parity bit of a (zero-extended) data word
package vpi_struct_bank_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Parity bit that makes the total number of ones (data + parity) even.
    function automatic logic even_par(input logic [31:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/vpi_struct_bank_clr.sv
// Clear sequencer for vpi_struct_bank.
// Walks entry index 0..DEPTH-1, one index per cycle, while the top zeroes
// that index in every channel. It also produces the registered write-ready
// flag, because writes are only accepted outside the clear sequence.
//   clk, rst_n    : clock, async active-low reset
//   i_clr_req     : start a clear (sampled in IDLE only)
//   o_busy        : high for exactly DEPTH cycles per clear
//   o_clr_active  : zero the entry at o_clr_addr this cycle
//   o_clr_addr    : entry index being cleared
//   o_wr_ready    : write accept (IDLE and out of reset)
module vpi_struct_bank_clr
    import vpi_struct_bank_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr_req,
    output logic          o_busy,
    output logic          o_clr_active,
    output logic [AW-1:0] o_clr_addr,
    output logic          o_wr_ready
);

    state_e        r_state;
    logic [AW-1:0] r_addr;
    logic          r_busy;
    logic          r_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_clr_req) begin
                        r_state <= CLEAR;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clr_req is ignored here; the sequence always runs to the end
                    if (r_addr == AW'(DEPTH - 1)) begin
                        r_state <= IDLE;
                        r_addr  <= '0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_addr  <= r_addr + AW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_clr_active = (r_state == CLEAR);
    assign o_clr_addr   = r_addr;
    assign o_wr_ready   = r_ready;

endmodule

// File: rtl/vpi_struct_bank.sv
// Multi-channel storage bank of packed-struct entries {s_field, p_field}.
// Storage r_mem is a plain unpacked array so an external VPI harness can
// read and deposit entries; a deposit behaves like any storage update.
// Optional macro PARITY_EN adds an even-parity bit per entry and a parity
// check on read responses; without it rd_par_err is tied low.
//   clk, rst_n                     : clock, async active-low reset
//   wr_valid/wr_ready/wr_chan/
//   wr_addr/wr_data                : write handshake
//   rd_valid/rd_chan/rd_addr       : read request, always accepted
//   rd_data_valid/rd_data          : registered read response (latency 1)
//   oor_err                        : pulse on out-of-range write or read
//   clr_req/busy                   : full clear request / clear in progress
//   wr_count                       : committed writes, saturating
//   rd_par_err                     : parity error on read response
module vpi_struct_bank
    import vpi_struct_bank_pkg::*;
#(
    parameter  int CHANNELS = 2,
    parameter  int DEPTH    = 4,
    parameter  int FIELD_W  = 3,
    parameter  int CNT_W    = 16,
    localparam int CW       = idx_w(CHANNELS),
    localparam int AW       = idx_w(DEPTH),
    localparam int EW       = FIELD_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [CW-1:0]    wr_chan,
    input  logic [AW-1:0]    wr_addr,
    input  logic [EW-1:0]    wr_data,
    input  logic             rd_valid,
    input  logic [CW-1:0]    rd_chan,
    input  logic [AW-1:0]    rd_addr,
    output logic             rd_data_valid,
    output logic [EW-1:0]    rd_data,
    output logic             oor_err,
    input  logic             clr_req,
    output logic             busy,
    output logic [CNT_W-1:0] wr_count,
    output logic             rd_par_err
);

    typedef struct packed {
        logic               s_field;
        logic [FIELD_W-1:0] p_field;
    } entry_t;

    entry_t r_mem [CHANNELS][DEPTH];

    entry_t           r_rd_data;
    logic             r_rd_data_valid;
    logic             r_oor_err;
    logic [CNT_W-1:0] r_wr_count;

    logic          w_clr_active;
    logic [AW-1:0] w_clr_addr;
    logic          w_wr_ready;
    logic          w_wr_fire;
    logic          w_wr_oor;
    logic          w_wr_commit;
    logic          w_rd_oor;
    entry_t        w_rd_entry;

    vpi_struct_bank_clr #(.DEPTH(DEPTH)) u_clr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr_req    (clr_req),
        .o_busy       (busy),
        .o_clr_active (w_clr_active),
        .o_clr_addr   (w_clr_addr),
        .o_wr_ready   (w_wr_ready)
    );

    assign w_wr_fire   = wr_valid && w_wr_ready;
    assign w_wr_oor    = (32'(wr_chan) >= CHANNELS) || (32'(wr_addr) >= DEPTH);
    assign w_wr_commit = w_wr_fire && !w_wr_oor;
    assign w_rd_oor    = (32'(rd_chan) >= CHANNELS) || (32'(rd_addr) >= DEPTH);
    // Only consumed when the read is in range.
    assign w_rd_entry  = r_mem[rd_chan][rd_addr];

    // Storage. Writes and the clear never overlap (wr_ready is low during
    // CLEAR); a read in the same cycle sees the old value (read-first).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int a = 0; a < DEPTH; a++)
                    r_mem[c][a] <= '0;
        end else begin
            if (w_wr_commit)
                r_mem[wr_chan][wr_addr] <= entry_t'(wr_data);
            if (w_clr_active)
                for (int c = 0; c < CHANNELS; c++)
                    r_mem[c][w_clr_addr] <= '0;
        end
    end

    // Read response, error pulse and write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data_valid <= 1'b0;
            r_rd_data       <= '0;
            r_oor_err       <= 1'b0;
            r_wr_count      <= '0;
        end else begin
            r_rd_data_valid <= rd_valid;
            if (rd_valid)
                r_rd_data <= w_rd_oor ? entry_t'('0) : w_rd_entry;
            r_oor_err <= (w_wr_fire && w_wr_oor) || (rd_valid && w_rd_oor);
            if (w_wr_commit && (r_wr_count != '1))
                r_wr_count <= r_wr_count + CNT_W'(1);
        end
    end

`ifdef PARITY_EN
    logic r_par [CHANNELS][DEPTH];
    logic r_rd_par_err;

    // Zero is its own correct parity, so clear/reset just zero the bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int a = 0; a < DEPTH; a++)
                    r_par[c][a] <= 1'b0;
            r_rd_par_err <= 1'b0;
        end else begin
            if (w_wr_commit)
                r_par[wr_chan][wr_addr] <= even_par(32'(wr_data));
            if (w_clr_active)
                for (int c = 0; c < CHANNELS; c++)
                    r_par[c][w_clr_addr] <= 1'b0;
            r_rd_par_err <= rd_valid && !w_rd_oor &&
                            (r_par[rd_chan][rd_addr] != even_par(32'(w_rd_entry)));
        end
    end

    assign rd_par_err = r_rd_par_err;
`else
    assign rd_par_err = 1'b0;
`endif

    assign wr_ready      = w_wr_ready;
    assign rd_data_valid = r_rd_data_valid;
    assign rd_data       = r_rd_data;
    assign oor_err       = r_oor_err;
    assign wr_count      = r_wr_count;

endmodule

// File: doc/vpi_struct_bank.md
Name: vpi_struct_bank

Overview:
Parametrised multi-channel storage bank of packed-struct entries. Successor to the fixed-shape public variable test module. Storage is a public_flat_rw unpacked array, so a VPI harness can read and deposit entries while RTL traffic runs. Adds a write handshake, registered reads, a sequenced clear FSM and an access counter, exercised from the regression top-level.

Parameters:
CHANNELS, 2, number of independent entry banks (>=1)
DEPTH, 4, entries per channel (>=2, need not be a power of 2)
FIELD_W, 3, width of p_field; entry width EW = FIELD_W+1
CNT_W, 16, width of the write counter

Ports:
clk  in  1  sole clock, all logic on posedge
rst_n  in  1  asynchronous, active-low reset
wr_valid  in  1  write request
wr_ready  out  1  write accept; transfer occurs when wr_valid && wr_ready on posedge clk
wr_chan  in  CW=max(1,$clog2(CHANNELS))  write channel
wr_addr  in  AW=max(1,$clog2(DEPTH))  write entry index
wr_data  in  EW  {s_field, p_field}
rd_valid  in  1  read request (always accepted)
rd_chan  in  CW  read channel
rd_addr  in  AW  read entry index
rd_data_valid  out  1  read response strobe
rd_data  out  EW  read response data
oor_err  out  1  one-cycle pulse: out-of-range channel/address on an accepted write or on a read
clr_req  in  1  request full clear
busy  out  1  high while the clear sequence runs
wr_count  out  CNT_W  number of committed writes, saturating
rd_par_err  out  1  parity error on the read response (see Optional Feature)

Behaviour:
- Storage mem[CHANNELS][DEPTH] of entry_t, tagged public_flat_rw @(posedge clk).
- Reset (rst_n low, asynchronous):
  - all mem entries = 0, FSM = IDLE.
  - wr_ready=0, rd_data_valid=0, rd_data=0, oor_err=0, busy=0, wr_count=0, rd_par_err=0.
  - wr_ready rises on the first clock edge after reset release.
- FSM states: IDLE, CLEAR.
  - IDLE: wr_ready=1. clr_req=1 -> CLEAR next cycle, clear address=0, busy=1.
  - CLEAR: wr_ready=0. Each cycle zeroes entry [addr] in every channel, then addr++. After entry DEPTH-1 is cleared -> IDLE, so busy is high for exactly DEPTH cycles. clr_req is ignored while in CLEAR.
- Write:
  - Committed on handshake; visible to reads issued from the next cycle onward.
  - Out-of-range chan or addr: write is dropped, oor_err pulses next cycle, wr_count unchanged.
  - wr_count increments per committed write and saturates at 2^CNT_W-1.
- Read:
  - Latency 1. rd_data_valid and rd_data are registered and appear the cycle after rd_valid.
  - Reads are allowed in both states.
  - Out-of-range read: rd_data=0, rd_data_valid=1, oor_err pulses.
  - Back-to-back reads give one response per cycle.
- Simultaneous events:
  - Read and write to the same entry in the same cycle: read returns the old data (read-first).
  - Write and clr_req in the same IDLE cycle: the write commits, then the clear wipes it.
  - CLEAR zeroing an entry in the same cycle it is read: the read returns the pre-clear data.
- Reset asserted mid-CLEAR: immediate return to IDLE with all entries zero.
- A VPI deposit into mem is treated as an ordinary storage update and is visible to the next read.

Optional Feature:
PARITY_EN.
- Defined: each mem entry carries an extra even-parity bit, computed on write and set to 0 by clear/reset (parity of zero is correct). On a read response, rd_par_err=1 if the stored parity mismatches the data. The VPI harness injects errors by depositing data bits only.
- Undefined: no parity storage, and rd_par_err is tied to 0.

Decomposition:
- Package vpi_struct_bank_pkg:
  - state_e enum {IDLE, CLEAR}
  - function to compute even parity
  - localparam helper for CW/AW (max(1,$clog2(n)))
- entry_t is a packed struct {logic s_field; logic [FIELD_W-1:0] p_field} declared in the module, because it depends on a parameter.
- One sub-module, vpi_struct_bank_clr: the CLEAR FSM and address counter, outputting busy, clr_active and clr_addr.

Test Plan:
- Reset, then write ch1/addr2 data 4'b1011, read ch1/addr2 next cycle -> rd_data_valid=1 one cycle later, rd_data=4'b1011, wr_count=1.
- Same-cycle read and write of ch0/addr0 (old 4'h3, new 4'hC) -> response 4'h3; a following read -> 4'hC.
- Fill every entry with nonzero data, pulse clr_req -> busy high exactly DEPTH=4 cycles, wr_ready low during those cycles, all reads afterwards return 0.
- Write with wr_addr=5 under DEPTH=5 -> oor_err pulse, wr_count unchanged. Write 2^CNT_W+3 times (CNT_W=4) -> wr_count=15.
- VPI deposit 4'h6 into mem[0][1], then RTL read -> 4'h6. With PARITY_EN: write 4'h1, deposit 4'h3 -> rd_par_err=1.
- Assert rst_n low in the middle of CLEAR -> all outputs return to reset values immediately, and a post-release read returns 0.
